sram_load_sequencer: RTL

Scheduler that owns the SRAM write window for the GSR, ECG and EEG memory wrappers. It quiesces the inference pipeline and drives the active-low `write_mode`. It assembles hypervectors from a narrow host chunk stream and writes them, one strobe per entry, into all nine IM/ProjM-pos/ProjM-neg SRAMs in a fixed order. It sits beside `hdc_sensor_fusion` in place of the FPGA-driven write-enable/address muxing.

---
 rtl/hdc_load_pkg.sv | 37 +++
 rtl/hv_chunk_assembler.sv | 52 +++++
 rtl/sram_load_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hdc_load_pkg.sv
// Shared types and helpers for the HDC SRAM load sequencer.
package hdc_load_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StFill,
    StWrite,
    StCheck,
    StDone
  } load_state_e;

  localparam int unsigned NumTargets = 9;

  localparam logic [1:0] ModGsr = 2'd0;
  localparam logic [1:0] ModEcg = 2'd1;
  localparam logic [1:0] ModEeg = 2'd2;

  localparam logic [1:0] MemIm  = 2'd0;
  localparam logic [1:0] MemPos = 2'd1;
  localparam logic [1:0] MemNeg = 2'd2;

  // One-hot SRAM select: bit index = 3*modality + memory.
  function automatic logic [NumTargets-1:0] target_onehot(input logic [1:0] modality,
                                                          input logic [1:0] memory);
    logic [3:0] idx;
    idx = 4'(modality) * 4'd3 + 4'(memory);
    return NumTargets'(1) << idx;
  endfunction

  // Number of host chunks needed to cover one hypervector.
  function automatic int unsigned calc_nchunk(input int unsigned hv_dim,
                                              input int unsigned chunk_w);
    return (hv_dim + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/hv_chunk_assembler.sv
// Assembles one hypervector from consecutive host chunks. Chunk k lands at
// bits [k*CHUNK_WIDTH +: CHUNK_WIDTH]; bits beyond HV_DIMENSION are dropped.
module hv_chunk_assembler
  import hdc_load_pkg::*;
#(
  parameter int unsigned HV_DIMENSION = 2000,
  parameter int unsigned CHUNK_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept,
  input  logic [CHUNK_WIDTH-1:0]  chunk,
  output logic [HV_DIMENSION-1:0] hv_next,
  output logic                    last
);

  localparam int unsigned NChunk   = calc_nchunk(HV_DIMENSION, CHUNK_WIDTH);
  localparam int unsigned CntWidth = (NChunk > 1) ? $clog2(NChunk) : 1;

  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [HV_DIMENSION-1:0] hv_q;

  // High while the chunk about to be accepted completes the vector.
  assign last = (cnt_q == CntWidth'(NChunk - 1));

  // Per-bit placement keeps every select constant.
  for (genvar b = 0; b < int'(HV_DIMENSION); b++) begin : g_place
    localparam int unsigned K = unsigned'(b) / CHUNK_WIDTH;
    localparam int unsigned J = unsigned'(b) % CHUNK_WIDTH;
    assign hv_next[b] = (accept && (cnt_q == CntWidth'(K))) ? chunk[J] : hv_q[b];
  end

  // Chunk index wraps after the final chunk of each vector.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = last ? '0 : cnt_q + CntWidth'(1);
    end
  end

  // Assembly register and chunk counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      hv_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hv_q  <= hv_next;
    end
  end

endmodule

// File: rtl/sram_load_sequencer.sv
// Owns the SRAM write window for the GSR/ECG/EEG memory wrappers: quiesces the
// pipeline, assembles hypervectors from the host chunk stream and writes every
// IM/ProjM-pos/ProjM-neg entry in address, memory, modality order.
// Optional trailer checksum: define LOAD_CHECKSUM_EN.
module sram_load_sequencer
  import hdc_load_pkg::*;
#(
  parameter int unsigned HV_DIMENSION = 2000,
  parameter int unsigned CHUNK_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned GSR_DEPTH    = 32,
  parameter int unsigned ECG_DEPTH    = 77,
  parameter int unsigned EEG_DEPTH    = 105
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_req,
  input  logic                    pipe_idle,
  input  logic [CHUNK_WIDTH-1:0]  chunk,
  input  logic                    chunk_valid,
  output logic                    chunk_ready,
  output logic                    write_mode,
  output logic                    wr_en,
  output logic [NumTargets-1:0]   wr_target,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [HV_DIMENSION-1:0] wr_hv,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_error
);

  load_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q, last_addr;
  logic [1:0]              mem_q, mem_next, mod_q;
  logic                    entry_last;
  logic                    fill_accept, chunk_last;
  logic [HV_DIMENSION-1:0] hv_next;
  logic [NumTargets-1:0]   wr_target_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [HV_DIMENSION-1:0] wr_hv_q;

  assign fill_accept = (state_q == StFill) && chunk_valid;

  hv_chunk_assembler #(
    .HV_DIMENSION (HV_DIMENSION),
    .CHUNK_WIDTH  (CHUNK_WIDTH)
  ) u_assembler (
    .clk     (clk),
    .rst     (rst),
    .accept  (fill_accept),
    .chunk   (chunk),
    .hv_next (hv_next),
    .last    (chunk_last)
  );

  // Last address of the modality currently being written, and memory successor.
  always_comb begin
    last_addr = ADDR_WIDTH'(EEG_DEPTH - 1);
    if (mod_q == ModGsr) begin
      last_addr = ADDR_WIDTH'(GSR_DEPTH - 1);
    end else if (mod_q == ModEcg) begin
      last_addr = ADDR_WIDTH'(ECG_DEPTH - 1);
    end
    unique case (mem_q)
      MemIm:   mem_next = MemPos;
      MemPos:  mem_next = MemNeg;
      default: mem_next = MemIm;
    endcase
  end

  assign entry_last = (mod_q == ModEeg) && (mem_q == MemNeg) && (addr_q == last_addr);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_d     = state_q;
    chunk_ready = 1'b0;
    write_mode  = 1'b1;
    wr_en       = 1'b0;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_req) state_d = StDrain;
      end
      StDrain: begin
        load_busy = 1'b1;
        if (pipe_idle) state_d = StFill;
      end
      StFill: begin
        load_busy   = 1'b1;
        write_mode  = 1'b0;
        chunk_ready = 1'b1;
        if (chunk_valid && chunk_last) state_d = StWrite;
      end
      StWrite: begin
        load_busy  = 1'b1;
        write_mode = 1'b0;
        wr_en      = 1'b1;
        if (entry_last) begin
`ifdef LOAD_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StFill;
        end
      end
      StCheck: begin
`ifdef LOAD_CHECKSUM_EN
        load_busy   = 1'b1;
        write_mode  = 1'b0;
        chunk_ready = 1'b1;
        if (chunk_valid) state_d = StDone;
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        load_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Entry position: address first, then memory, then modality.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      mem_q  <= MemIm;
      mod_q  <= ModGsr;
    end else if (state_q == StWrite) begin
      if (addr_q == last_addr) begin
        addr_q <= '0;
        if (mem_q == MemNeg) begin
          mem_q <= MemIm;
          mod_q <= entry_last ? ModGsr : mod_q + 2'd1;
        end else begin
          mem_q <= mem_next;
        end
      end else begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Write bus is captured as the final chunk lands and held outside WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_target_q <= '0;
      wr_addr_q   <= '0;
      wr_hv_q     <= '0;
    end else if (fill_accept && chunk_last) begin
      wr_target_q <= target_onehot(mod_q, mem_q);
      wr_addr_q   <= addr_q;
      wr_hv_q     <= hv_next;
    end
  end

  assign wr_target = wr_target_q;
  assign wr_addr   = wr_addr_q;
  assign wr_hv     = wr_hv_q;

`ifdef LOAD_CHECKSUM_EN
  logic [CHUNK_WIDTH-1:0] csum_q;
  logic                   error_q;

  // Running XOR of data chunks; sticky mismatch flag cleared on a new load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (state_q == StIdle && load_req) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (fill_accept) csum_q <= csum_q ^ chunk;
      if (state_q == StCheck && chunk_valid && chunk != csum_q) error_q <= 1'b1;
    end
  end

  assign load_error = error_q;
`else
  assign load_error = 1'b0;
`endif

endmodule
